// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states, operand
// forwarding selects and default widths.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_FLUSH    = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  localparam int DEF_REG_BITS = 5;
  localparam int DEF_PC_BITS  = 5;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational register-match logic: load-use detection and per-operand
// forwarding selection. Register 0 never matches.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_BITS = DEF_REG_BITS
) (
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [REG_BITS-1:0] ex_write_reg,
  input  logic                ex_reg_wrenable,
  input  logic                ex_mem_to_reg,
  input  logic [REG_BITS-1:0] wb_write_reg,
  input  logic                wb_reg_wrenable,
  output logic                load_use,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b
);

  logic ex_live_s;
  logic wb_live_s;
  logic ex_a_s, ex_b_s, wb_a_s, wb_b_s;

  always_comb begin
    ex_live_s = ex_reg_wrenable && (ex_write_reg != '0);
    wb_live_s = wb_reg_wrenable && (wb_write_reg != '0);
    ex_a_s    = ex_live_s && (ex_write_reg == id_rs1);
    ex_b_s    = ex_live_s && (ex_write_reg == id_rs2);
    wb_a_s    = wb_live_s && (wb_write_reg == id_rs1);
    wb_b_s    = wb_live_s && (wb_write_reg == id_rs2);

    load_use  = ex_mem_to_reg && ((ex_a_s && id_uses_rs1) || (ex_b_s && id_uses_rs2));

    // A load result is not yet available in EX, so only ALU results forward from EX.
    fwd_a = FWD_RF;
    if (ex_a_s && !ex_mem_to_reg) begin
      fwd_a = FWD_EX;
    end else if (wb_a_s) begin
      fwd_a = FWD_WB;
    end else begin
      fwd_a = FWD_RF;
    end

    fwd_b = FWD_RF;
    if (ex_b_s && !ex_mem_to_reg) begin
      fwd_b = FWD_EX;
    end else if (wb_b_s) begin
      fwd_b = FWD_WB;
    end else begin
      fwd_b = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: Mealy FSM arbitrating memory wait, jump flush
// and load-use stall, plus saturating stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_BITS = DEF_REG_BITS,
  parameter int PC_BITS  = DEF_PC_BITS,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [REG_BITS-1:0] ex_write_reg,
  input  logic                ex_reg_wrenable,
  input  logic                ex_mem_to_reg,
  input  logic                ex_should_jump,
  input  logic [PC_BITS-1:0]  ex_jump_pc,
  input  logic [REG_BITS-1:0] wb_write_reg,
  input  logic                wb_reg_wrenable,
  input  logic                mem_req,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic                fd_en,
  output logic                ex_en,
  output logic                fd_flush,
  output logic                ex_flush,
  output logic                pc_sel,
  output logic [PC_BITS-1:0]  jump_pc,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [CNT_BITS-1:0] stall_cycles,
  output logic [CNT_BITS-1:0] flush_count
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [PC_BITS-1:0]  jump_pc_q, jump_pc_d;
  logic [CNT_BITS-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_BITS-1:0] flush_count_q, flush_count_d;
  logic                load_use_s;
  logic [1:0]          haz_fwd_a_s, haz_fwd_b_s;
  logic                mem_wait_s;
  logic                jump_taken_s;

  hazard_detect #(.REG_BITS(REG_BITS)) u_hazard (
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_write_reg    (ex_write_reg),
    .ex_reg_wrenable (ex_reg_wrenable),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .wb_write_reg    (wb_write_reg),
    .wb_reg_wrenable (wb_reg_wrenable),
    .load_use        (load_use_s),
    .fwd_a           (haz_fwd_a_s),
    .fwd_b           (haz_fwd_b_s)
  );

  // MEM_WAIT with the access completing behaves exactly like RUN.
  always_comb begin
    mem_wait_s   = mem_req && !mem_ready;
    state_d      = ST_RUN;
    pc_en        = 1'b1;
    fd_en        = 1'b1;
    ex_en        = 1'b1;
    fd_flush     = 1'b0;
    ex_flush     = 1'b0;
    pc_sel       = 1'b0;
    jump_taken_s = 1'b0;
    fwd_a        = haz_fwd_a_s;
    fwd_b        = haz_fwd_b_s;

    if (reset) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      ex_en    = 1'b0;
      fd_flush = 1'b1;
      ex_flush = 1'b1;
      fwd_a    = FWD_RF;
      fwd_b    = FWD_RF;
    end else if (mem_wait_s) begin
      pc_en   = 1'b0;
      fd_en   = 1'b0;
      ex_en   = 1'b0;
      state_d = ST_MEM_WAIT;
    end else if (state_q == ST_FLUSH) begin
      ex_flush = 1'b1;
    end else if (ex_should_jump) begin
      pc_sel       = 1'b1;
      fd_flush     = 1'b1;
      ex_flush     = 1'b1;
      jump_taken_s = 1'b1;
      state_d      = ST_FLUSH;
    end else if (load_use_s) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      ex_flush = 1'b1;
    end else begin
      state_d = ST_RUN;
    end

    jump_pc_d = jump_taken_s ? ex_jump_pc : jump_pc_q;
    if (reset) begin
      jump_pc = '0;
    end else begin
      jump_pc = jump_taken_s ? ex_jump_pc : jump_pc_q;
    end

    stall_cycles_d = stall_cycles_q;
    if (!pc_en && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end

    flush_count_d = flush_count_q;
    if (jump_taken_s && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // State, held jump target and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      jump_pc_q      <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      jump_pc_q      <= jump_pc_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule
